// File: rtl/result_tx_pkg.sv
// -----------------------------------------------------------------------------
// result_tx_pkg
//   Shared definitions for the result UART transmitter:
//     - tx_state_e    : transmitter FSM states
//     - BYTE_PREFIX   : upper three bits prepended to the 5-bit result
//     - clks_per_bit(): clock cycles per serial bit (integer division)
// -----------------------------------------------------------------------------
package result_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [2:0] BYTE_PREFIX = 3'b000;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/result_tx_fifo.sv
// -----------------------------------------------------------------------------
// result_tx_fifo
//   Synchronous single-clock FIFO with first-word fall-through read data.
//   Parameters:
//     DEPTH   : number of entries (power of two, >= 2)
//     WIDTH   : entry width in bits
//   Ports:
//     clk     : clock
//     rst     : synchronous active-high reset (empties the FIFO)
//     wr_en   : write wr_data this edge (caller guarantees not full, or rd_en)
//     wr_data : write data
//     rd_en   : pop the head entry this edge (caller guarantees not empty)
//     rd_data : current head entry
//     empty   : no entries held
//     full    : DEPTH entries held
// -----------------------------------------------------------------------------
module result_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    // One extra bit so that DEPTH entries is distinguishable from zero.
    logic [AW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
//   Buffers 5-bit classification results and sends each one as a UART byte
//   {3'b000, result} LSB first: start bit, 8 data bits, optional even parity
//   bit, stop bit. Results arriving while the buffer is full are dropped and
//   counted.
//   Build option: define RESULT_TX_PARITY_EN to append an even-parity bit
//   (11-bit frame); otherwise the frame is 10 bits.
//   Parameters:
//     CLK_HZ     : clock frequency in Hz
//     BAUD       : serial bit rate
//     FIFO_DEPTH : result buffer entries (power of two, >= 2)
//   Ports:
//     clk               : clock
//     rst               : synchronous active-high reset
//     result_data_valid : result_data is valid this cycle
//     result_data       : 5-bit result
//     tx                : serial line, idle high (registered)
//     busy              : frame in progress or buffer non-empty
//     fifo_full         : buffer holds FIFO_DEPTH entries
//     drop_pulse        : one-cycle pulse per discarded result
//     drop_cnt          : saturating count of discarded results
// -----------------------------------------------------------------------------
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       result_data_valid,
    input  logic [4:0] result_data,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       drop_pulse,
    output logic [7:0] drop_cnt
);

    localparam int unsigned CPB      = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             drop_pulse_q, drop_pulse_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
`ifdef RESULT_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic       fifo_push, fifo_pop, fifo_empty, fifo_full_w, drop;
    logic [4:0] fifo_head;
    logic       bit_done;

    result_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_push),
        .wr_data (result_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full_w)
    );

    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        fifo_pop  = 1'b0;
`ifdef RESULT_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != IDLE) cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = {BYTE_PREFIX, fifo_head};
`ifdef RESULT_TX_PARITY_EN
                    parity_d = ^{BYTE_PREFIX, fifo_head};
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // tx is the registered image of the current state, so the line lags
        // the FSM by exactly one cycle for every bit alike.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
`ifdef RESULT_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // A full buffer still accepts a write on the edge its head is popped.
    assign fifo_push = result_data_valid && !rst && (!fifo_full_w || fifo_pop);
    assign drop      = result_data_valid && !rst && fifo_full_w && !fifo_pop;

    always_comb begin
        drop_pulse_d = drop;
        drop_cnt_d   = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
`ifdef RESULT_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef RESULT_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign fifo_full  = fifo_full_w;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
